// File: rtl/uart_tx_queue.sv
// uart_tx_queue: circular byte FIFO feeding one UART transmitter over a held tx_start / tx_busy handshake.
// Define UART_TXQ_STATS_EN to add the sent_cnt frame counter port.
module uart_tx_queue #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
`ifdef UART_TXQ_STATS_EN
  ,
  output logic [15:0]              sent_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [7:0]    tx_data_r;
  logic          tx_start_r;
  logic          push_s;
  logic          pop_s;
  logic          load_s;
  logic          empty_s;
  logic          full_s;

  // Flags decode registered count only, so wr_ready never depends on wr_valid.
  assign empty_s  = (count_r == {CW{1'b0}});
  assign full_s   = (count_r == CW'(DEPTH));
  assign push_s   = wr_valid & ~full_s;

  assign empty    = empty_s;
  assign full     = full_s;
  assign wr_ready = ~full_s;
  assign count    = count_r;
  assign tx_start = tx_start_r;
  assign tx_data  = tx_data_r;

  // Next-state logic: launch only onto an idle line, hold the request until acknowledged.
  always_comb begin
    state_nx_s = state_r;
    pop_s      = 1'b0;
    load_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && !tx_busy) begin
          state_nx_s = ST_LAUNCH;
          load_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (tx_busy) begin
          state_nx_s = ST_DRAIN;
          pop_s      = 1'b1;
        end else begin
          state_nx_s = ST_LAUNCH;
        end
      end
      ST_DRAIN: begin
        if (!tx_busy) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state plus the registered launch request and launch byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      state_r    <= state_nx_s;
      tx_start_r <= (state_nx_s == ST_LAUNCH);
      if (load_s) begin
        tx_data_r <= mem_r[rd_ptr_r];
      end else begin
        tx_data_r <= tx_data_r;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array carries no reset; count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

`ifdef UART_TXQ_STATS_EN
  logic [15:0] sent_cnt_r;

  // Frames handed to the transmitter; wraps at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sent_cnt_r <= 16'h0000;
    end else if (pop_s) begin
      sent_cnt_r <= sent_cnt_r + 16'h0001;
    end else begin
      sent_cnt_r <= sent_cnt_r;
    end
  end

  assign sent_cnt = sent_cnt_r;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized self-checking bench for uart_tx_queue against a queue-based reference of the launch protocol.
// Stats checks are included when UART_TXQ_STATS_EN is defined.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;

  logic                   clk;
  logic                   rst;
  logic                   wr_valid;
  logic [7:0]             wr_data;
  logic                   wr_ready;
  logic                   tx_busy;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;
  logic                   full;
`ifdef UART_TXQ_STATS_EN
  logic [15:0]            sent_cnt;
`endif

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .count    (count),
    .empty    (empty),
    .full     (full)
`ifdef UART_TXQ_STATS_EN
    ,
    .sent_cnt (sent_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // reference: bytes held, whether a launch request is outstanding, whether a frame is on the line
  logic [7:0] m_q[$];
  logic [7:0] launched[$];
  bit         m_req;
  bit         m_frame;
  logic [7:0] m_data;
  int         m_sent;

  // transmitter / stimulus knobs
  bit hold_busy, ext_en, rand_en, log_en, gap_en, in_ack, prev_start;
  int busy_left, ack_wait, ack_delay, frame_len, fall_cyc, t0, n_pushed;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_req = 1'b0; m_frame = 1'b0; m_data = 8'h00; m_sent = 0;
    prev_start = 1'b0; busy_left = 0; ack_wait = ack_delay - 1; fall_cyc = -1;
  endtask

  task automatic check_outputs();
    check_eq("tx_start", 32'(tx_start), 32'(m_req));
    check_eq("tx_data", 32'(tx_data), 32'(m_data));
    check_eq("count", 32'(count), 32'(m_q.size()));
    check_eq("empty", 32'(empty), 32'(m_q.size() == 0));
    check_eq("full", 32'(full), 32'(m_q.size() == DEPTH));
    check_eq("wr_ready", 32'(wr_ready), 32'(m_q.size() < DEPTH));
`ifdef UART_TXQ_STATS_EN
    check_eq("sent_cnt", 32'(sent_cnt), 32'(m_sent % 65536));
`endif
  endtask

  // One clock: advance the reference, compare, then let the transmitter model react.
  task automatic cycle();
    bit push, pop;
    @(posedge clk);
    push = wr_valid && (m_q.size() < DEPTH);
    pop  = 1'b0;
    if (m_req) begin
      if (tx_busy) begin pop = 1'b1; m_req = 1'b0; m_frame = 1'b1; m_sent++; end
    end else if (m_frame) begin
      if (!tx_busy) m_frame = 1'b0;
    end else if (m_q.size() != 0 && !tx_busy) begin
      m_req = 1'b1; m_data = m_q[0];
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin m_q.push_back(wr_data); n_pushed++; end
    cyc++;
    #1;
    check_outputs();
    if (tx_start && !prev_start) begin
      if (log_en) launched.push_back(tx_data);
      if (gap_en && fall_cyc >= 0) check_eq("gap", 32'(cyc - fall_cyc), 32'd2);
      fall_cyc = -1;
    end
    prev_start = tx_start;
    if (hold_busy) tx_busy = 1'b1;
    else if (tx_busy) begin
      busy_left--;
      if (busy_left <= 0) begin tx_busy = 1'b0; if (in_ack) fall_cyc = cyc; end
    end else if (tx_start) begin
      if (ack_wait <= 0) begin
        tx_busy = 1'b1; busy_left = frame_len; in_ack = 1'b1;
        if (rand_en) begin frame_len = $urandom_range(1, 6); ack_delay = $urandom_range(1, 3); end
        ack_wait = ack_delay - 1;
      end else ack_wait--;
    end else if (ext_en && $urandom_range(0, 29) == 0) begin
      tx_busy = 1'b1; busy_left = 2; in_ack = 1'b0;
    end
  endtask

  task automatic drain(input int bound, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      cycle();
      done = (m_q.size() == 0) && !m_req && !m_frame && !tx_busy;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic fill_stalled(input bit ramp);
    hold_busy = 1'b1; tx_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = ramp ? 8'(i) : 8'($urandom); cycle();
    end
    wr_valid = 1'b0;
  endtask

  task automatic release_busy();
    hold_busy = 1'b0; tx_busy = 1'b0; busy_left = 0; fall_cyc = -1;
  endtask

  initial begin
    rst = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; tx_busy = 1'b0;
    hold_busy = 0; ext_en = 0; rand_en = 0; log_en = 0; gap_en = 0; in_ack = 0;
    ack_delay = 3; frame_len = 10; n_pushed = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    check_outputs();

    // idle after reset: no launch
    repeat (100) cycle();

    // single byte 8'hA5
    t0 = cyc;
    wr_valid = 1'b1; wr_data = 8'hA5; cycle(); wr_valid = 1'b0;
    for (int i = 0; i < 10 && !tx_start; i++) cycle();
    check_eq("latency", 32'(cyc - t0), 32'd2);
    check_eq("single_data", 32'(tx_data), 32'hA5);
    drain(40, "single_done");

    // fill and stall, then a 17th write must be refused
    fill_stalled(1'b1);
    wr_valid = 1'b1; wr_data = 8'hEE;
    repeat (3) cycle();
    wr_valid = 1'b0;
    check_eq("full_count", 32'(count), 32'(DEPTH));
    check_eq("full_flag", 32'(full), 32'd1);
    check_eq("full_ready", 32'(wr_ready), 32'd0);

    // drain in order with a 10-cycle frame
    launched.delete();
    log_en = 1'b1; gap_en = 1'b1; frame_len = 10; ack_delay = 1; ack_wait = 0;
    release_busy();
    drain(600, "drain_done");
    log_en = 1'b0; gap_en = 1'b0;
    check_eq("drain_len", 32'(launched.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < launched.size(); i++)
      check_eq("drain_order", 32'(launched[i]), 32'(i));

    // full queue, then heavy random writes with randomized frames (pointer wrap, push+pop)
    fill_stalled(1'b0);
    release_busy();
    rand_en = 1'b1; ext_en = 1'b1;
    t0 = n_pushed;
    for (int i = 0; i < 3000 && (n_pushed - t0) < 60; i++) begin
      wr_valid = ($urandom_range(0, 7) != 0); wr_data = 8'($urandom);
      cycle();
    end
    wr_valid = 1'b0;
    check_eq("wrap_pushes", 32'(n_pushed - t0 >= 60), 32'd1);
    ext_en = 1'b0;
    drain(1000, "rand_done");

    // reset while a launch is pending with 5 bytes queued
    rand_en = 1'b0; ack_delay = 3; frame_len = 4; ack_wait = 2;
    hold_busy = 1'b1; tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin wr_valid = 1'b1; wr_data = 8'(8'h50 + i); cycle(); end
    wr_valid = 1'b0;
    release_busy();
    for (int i = 0; i < 10 && !tx_start; i++) cycle();
    check_eq("pre_rst_start", 32'(tx_start), 32'd1);
    #3; rst = 1'b0; tx_busy = 1'b0;
    #1;
    check_eq("rst_start", 32'(tx_start), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_ready", 32'(wr_ready), 32'd1);
`ifdef UART_TXQ_STATS_EN
    check_eq("rst_sent", 32'(sent_cnt), 32'd0);
`endif
    model_reset();
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin wr_valid = 1'b1; wr_data = 8'(8'hC0 + i); cycle(); end
    wr_valid = 1'b0;
    drain(200, "post_rst_done");
    check_eq("post_rst_count", 32'(count), 32'd0);
`ifdef UART_TXQ_STATS_EN
    check_eq("sent_three", 32'(sent_cnt), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
